// File: rtl/aes_inv_key_sched_pkg.sv
// Shared constants for the AES-128 inverse key schedule: round count, Rcon,
// S-box and the FSM state encoding.
package aes_inv_key_sched_pkg;

  localparam logic [3:0] AES_ROUNDS = 4'd10;
  localparam int         NUM_BYTES  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_REV  = 2'd2
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aes_inv_key_sched_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
import aes_inv_key_sched_pkg::*;

module aes_sub_word (
  input  logic [31:0] word,
  output logic [31:0] sub
);

  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_byte
    assign sub[8*g +: 8] = sbox(word[8*g +: 8]);
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: expands forward to round key 10 in one
// working register, then walks it back to key 0 one handshake at a time.
import aes_inv_key_sched_pkg::*;

module aes_inv_key_sched (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic         key_valid,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  state_t       state, nstate;
  logic [127:0] wk;
  logic [3:0]   ctr;
  logic [31:0]  w0, w1, w2, w3, w3p;
  logic [31:0]  sw_in, sw_out, t;
  logic [127:0] fwd_key, rev_key;

  assign {w0, w1, w2, w3} = wk;
  assign w3p = w3 ^ w2;

  // One S-box bank shared by both directions; REV feeds the recovered w3.
  assign sw_in = (state == S_REV) ? w3p : w3;

  aes_sub_word u_sub_word (
    .word (sw_in),
    .sub  (sw_out)
  );

  // ctr is cnt in FWD and round_idx in REV, so it always selects the right Rcon.
  assign t = {sw_out[23:0], sw_out[31:24]} ^ {rcon(ctr), 24'h0};

  always_comb begin
    logic [31:0] f0, f1, f2;
    f0 = w0 ^ t;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    fwd_key = {f0, f1, f2, w3 ^ f2};
    rev_key = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3p};
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (start) nstate = S_FWD;
      S_FWD:   if (ctr == AES_ROUNDS) nstate = S_REV;
      S_REV:   if (key_ready && ctr == 4'd0) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      wk    <= '0;
      ctr   <= '0;
      done  <= 1'b0;
    end else begin
      state <= nstate;
      done  <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          wk  <= key_in;
          ctr <= 4'd1;
        end
        S_FWD: begin
          wk <= fwd_key;
          if (ctr != AES_ROUNDS) ctr <= ctr + 4'd1;
        end
        S_REV: if (key_ready) begin
          if (ctr != 4'd0) begin
            wk  <= rev_key;
            ctr <= ctr - 4'd1;
          end else begin
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign key_out   = wk;
  assign key_valid = (state == S_REV);
  assign round_idx = (state == S_REV) ? ctr : 4'd0;
  assign busy      = (state != S_IDLE);

endmodule
